// File: rtl/rv32ima_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rv32ima_pkg : shared types for the rv32ima memory-port arbiter   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package rv32ima_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    IFETCH = 2'd1,
    DATA   = 2'd2
  } arb_owner_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP   = 3'd3,
    LOCKED = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic       wen;
    logic [3:0] strb;
    word_t      addr;
    word_t      wdata;
  } mem_cmd_t;

  localparam logic [3:0] c_strb_full = 4'hF;

endpackage
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_prio : winner select and ifetch starvation streak        |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4,
  parameter int STREAK_W     = 3
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_req,
  input  logic d_req,
  input  logic arb_en,
  input  logic locked,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [STREAK_W-1:0] c_limit = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] r_streak;
  logic                w_starved;

  // Data normally wins; a saturated streak hands one arbitration to ifetch
  // unless the port is locked for an AMO sequence.
  assign w_starved = i_req && (r_streak == c_limit);
  assign grant_d   = arb_en && d_req && (locked || !w_starved);
  assign grant_i   = arb_en && !locked && i_req && !grant_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_streak <= '0;
    end else if (grant_i) begin
      r_streak <= '0;
    end else if (grant_d && i_req && (r_streak != c_limit)) begin
      r_streak <= r_streak + STREAK_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between ifetch and     |
// |                    data requesters, with AMO lock support        |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module mem_port_arbiter
  import rv32ima_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STREAK_W     = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       i_req,
  input  word_t      i_addr,
  output word_t      i_rdata,
  output logic       i_ready,
  input  logic       d_req,
  input  logic       d_wen,
  input  logic [3:0] d_strb,
  input  word_t      d_addr,
  input  word_t      d_wdata,
  input  logic       d_lock,
  output word_t      d_rdata,
  output logic       d_ready,
  output logic       m_req,
  output logic       m_wen,
  output logic [3:0] m_strb,
  output word_t      m_addr,
  output word_t      m_wdata,
  input  word_t      m_rdata,
  input  logic       m_ready,
  output arb_owner_t owner
);

  arb_state_t r_state;
  mem_cmd_t   r_cmd;
  arb_owner_t r_owner;
  logic       r_m_req;
  logic       r_i_ready;
  logic       r_d_ready;
  logic       r_lock;
  word_t      r_i_rdata;
  word_t      r_d_rdata;

  logic w_locked;
  logic w_arb_en;
  logic w_grant_i;
  logic w_grant_d;

  // The first LOCKED cycle carries the ready pulse, so the still-high d_req
  // of the finished access must not be taken as a new request.
  assign w_locked = (r_state == LOCKED);
  assign w_arb_en = (r_state == IDLE) || (w_locked && !r_d_ready);

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .STREAK_W    (STREAK_W)
  ) u_prio (
    .clk    (clk),
    .nrst   (nrst),
    .i_req  (i_req),
    .d_req  (d_req),
    .arb_en (w_arb_en),
    .locked (w_locked),
    .grant_i(w_grant_i),
    .grant_d(w_grant_d)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_cmd     <= '0;
      r_owner   <= NONE;
      r_m_req   <= 1'b0;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_lock    <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      unique case (r_state)
        IDLE, LOCKED: begin
          if (w_grant_d) begin
            r_cmd   <= '{wen: d_wen, strb: d_strb, addr: d_addr, wdata: d_wdata};
            r_lock  <= d_lock;
            r_m_req <= 1'b1;
            r_owner <= DATA;
            r_state <= BUSY_D;
          end else if (w_grant_i) begin
            r_cmd   <= '{wen: 1'b0, strb: c_strb_full, addr: i_addr, wdata: '0};
            r_m_req <= 1'b1;
            r_owner <= IFETCH;
            r_state <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (m_ready) begin
            r_i_rdata <= m_rdata;
            r_i_ready <= 1'b1;
            r_m_req   <= 1'b0;
            r_owner   <= NONE;
            r_state   <= RESP;
          end
        end
        BUSY_D: begin
          if (m_ready) begin
            r_d_rdata <= m_rdata;
            r_d_ready <= 1'b1;
            r_m_req   <= 1'b0;
            r_owner   <= r_lock ? DATA : NONE;
            r_state   <= r_lock ? LOCKED : RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_owner <= NONE;
        end
      endcase
    end
  end

  assign m_req   = r_m_req;
  assign m_wen   = r_cmd.wen;
  assign m_strb  = r_cmd.strb;
  assign m_addr  = r_cmd.addr;
  assign m_wdata = r_cmd.wdata;
  assign i_rdata = r_i_rdata;
  assign i_ready = r_i_ready;
  assign d_rdata = r_d_rdata;
  assign d_ready = r_d_ready;
  assign owner   = r_owner;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the rv32ima system between the instruction-fetch requester and the data (load/store/AMO) requester of the datapath.
- Picks a winner, registers the winner's command onto the memory port, and holds it until memory acknowledges.
- Returns read data to the winner with a one-cycle ready pulse.
- Supports a lock for AMO read-modify-write and a starvation guard for instruction fetch.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants made while i_req is pending, after which ifetch wins the next unlocked arbitration.
- STREAK_W, 3: width of the streak counter; must satisfy 2^STREAK_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- nrst  in  1  asynchronous, active-low reset.
- i_req  in  1  ifetch request; held until i_ready.
- i_addr  in  32 (word_t)  fetch address.
- i_rdata  out  32 (word_t)  fetch data; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse for ifetch.
- d_req  in  1  data request; held until d_ready.
- d_wen  in  1  1=store, 0=load.
- d_strb  in  4  byte strobes.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_lock  in  1  keep the port owned by data after this access completes.
- d_rdata  out  32  load data; valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- m_req  out  1  memory request.
- m_wen  out  1  memory write enable.
- m_strb  out  4  memory byte strobes.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; sampled when m_ready=1.
- m_ready  in  1  memory acknowledge; any number of wait cycles allowed.
- owner  out  2  current owner (arb_owner_t): NONE=0, IFETCH=1, DATA=2.

Behaviour:
- **Reset (async, nrst=0):**
  - state=IDLE; all outputs 0 (m_*, i_ready, d_ready, i_rdata, d_rdata, owner=NONE).
  - Streak counter and lock flag cleared.
  - An in-flight access is abandoned: m_req falls immediately, no ready pulse is issued.
- **FSM states:** IDLE, BUSY_I, BUSY_D, RESP, LOCKED.
- **IDLE:**
  - d_req only -> BUSY_D.
  - i_req only -> BUSY_I.
  - Both asserted -> data wins, unless streak==STARVE_LIMIT, in which case ifetch wins.
  - On the grant edge, the winner's addr/wdata/strb/wen are registered onto m_*, and m_req=1 from the next cycle. Ifetch always drives m_wen=0 and m_strb=4'hF.
- **BUSY_x:**
  - m_* are held stable until m_ready=1 is sampled.
  - On that edge: m_rdata is captured into x_rdata, x_ready=1 for exactly one cycle, m_req=0, and the FSM moves to RESP (or LOCKED if data was granted with d_lock=1).
- **RESP:**
  - One dead cycle; i_req and d_req are ignored (the requester drops req on seeing ready). Then IDLE.
  - Minimum cost: 3 cycles per access, with ready in cycle 2 after the req edge.
- **LOCKED:**
  - Ready pulse is issued as in RESP; owner stays DATA.
  - Only d_req is accepted -> BUSY_D. i_req waits indefinitely.
  - The lock is released when a locked-phase data access completes with d_lock=0: go to RESP, then IDLE.
- **Streak counter:**
  - +1 on each data grant made while i_req=1; saturates at STARVE_LIMIT.
  - Cleared on every ifetch grant.
  - Unchanged on data grants made while i_req=0.
- **Other rules:**
  - owner reflects BUSY_I/BUSY_D/LOCKED, and NONE in IDLE/RESP (unlocked).
  - x_rdata holds its last value between pulses; the non-winner's rdata is never disturbed.
  - A store completion produces d_ready with d_rdata = the captured m_rdata (don't-care, still registered).
  - m_ready outside BUSY_x is ignored.

Decomposition:
- Add to rv32ima_pkg: arb_owner_t (2-bit enum NONE/IFETCH/DATA); arb_state_t (IDLE/BUSY_I/BUSY_D/RESP/LOCKED); mem_cmd_t struct {wen, strb[3:0], addr word_t, wdata word_t}.
- One sub-module is natural: mem_arb_prio — combinational winner select plus the streak counter register. Takes the same clk/nrst.

Test Plan:
- Single fetch: i_req with i_addr=0x80000000 and memory ready after 2 waits, m_rdata=0x00000013. -> m_addr=0x80000000, m_wen=0; i_ready pulses once with i_rdata=0x00000013; owner returns to NONE.
- Collision: i_req and d_req asserted on the same edge (d store 0xBEEFBEEF @0x80001000, strb=F). -> data is served first (m_wen=1, m_wdata=0xBEEFBEEF); fetch is served after the RESP cycle; i_ready occurs after d_ready.
- Starvation: i_req held, d_req re-asserted continuously, STARVE_LIMIT=4. -> exactly 4 data grants, then an ifetch grant; streak returns to 0.
- AMO lock: load @0x80002000 with d_lock=1 (m_rdata=5), i_req pending, then store 6 with d_lock=0. -> no ifetch grant between the two; owner=DATA throughout; ifetch granted after release.
- Reset mid-access: nrst low while in BUSY_D with m_req=1. -> m_req=0 asynchronously; no d_ready; after release the FSM is in IDLE and a new fetch completes normally.
- Zero-wait memory: m_ready tied 1, fetches back-to-back. -> one i_ready every 3 cycles; m_req low during RESP.
